// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the pipeline sequencer
package pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_MEMWAIT,
    ST_DRAIN,
    ST_DONE
  } pipe_state_t;

  localparam int         DRAIN_CYCLES_DEF = 4;
  localparam int         REG_W            = 5;
  localparam logic [4:0] REG_ZERO         = 5'd0;

endpackage

// File: rtl/pipe_ctrl_if.sv
// rtl/pipe_ctrl_if.sv - hazard/branch/memory inputs and per-stage controls
interface pipe_ctrl_if;
  import pipe_pkg::*;

  logic             start;
  logic             halt;
  logic             idex_memread;
  logic [REG_W-1:0] idex_rt;
  logic [REG_W-1:0] ifid_rs;
  logic [REG_W-1:0] ifid_rt;
  logic             branch_taken;
  logic             jump;
  logic             dmem_req;
  logic             dmem_ready;

  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             idex_bubble;
  logic             exmem_write;
  logic             memwb_write;

  modport master (
    output start, halt, idex_memread, idex_rt, ifid_rs, ifid_rt,
           branch_taken, jump, dmem_req, dmem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write
  );

  modport slave (
    input  start, halt, idex_memread, idex_rt, ifid_rs, ifid_rt,
           branch_taken, jump, dmem_req, dmem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write
  );
endinterface

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - wrapping event counter with synchronous clear
module perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - 5-stage pipeline sequencer: stall/flush/freeze controls,
// start/run/drain/done lifecycle and performance counters
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  pipe_ctrl_if.slave       bus,
  output logic             running_o,
  output logic             done_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] memwait_cnt_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  pipe_state_t   state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;

  logic pc_we, ifid_we, flush, bubble, exmem_we, memwb_we;
  logic stall_inc, flush_inc, memwait_inc, cycle_inc;
  logic hazard, mem_stall;
  logic [CNT_W-1:0] stall_q, flush_q, memwait_q, cycle_q;

  assign hazard = bus.idex_memread && (bus.idex_rt != REG_ZERO) &&
                  ((bus.idex_rt == bus.ifid_rs) || (bus.idex_rt == bus.ifid_rt));
  assign mem_stall = bus.dmem_req && !bus.dmem_ready;

  always_comb begin
    state_d     = state_q;
    drain_d     = drain_q;
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    flush       = 1'b0;
    bubble      = 1'b0;
    exmem_we    = 1'b0;
    memwb_we    = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    memwait_inc = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN, ST_MEMWAIT: begin
        // Once in MEMWAIT only ready ends the freeze, regardless of req.
        if ((state_q == ST_RUN) ? mem_stall : !bus.dmem_ready) begin
          memwait_inc = 1'b1;
          state_d     = ST_MEMWAIT;
        end else begin
          state_d  = ST_RUN;
          exmem_we = 1'b1;
          memwb_we = 1'b1;
          if (hazard) begin
            bubble    = 1'b1;
            stall_inc = 1'b1;
          end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            if (bus.branch_taken || bus.jump) begin
              flush     = 1'b1;
              flush_inc = 1'b1;
            end
          end
          if ((state_q == ST_RUN) && bus.halt) begin
            state_d = ST_DRAIN;
            drain_d = DW'(DRAIN_CYCLES - 1);
          end
        end
      end
      ST_DRAIN: begin
        if (mem_stall) begin
          memwait_inc = 1'b1;
        end else begin
          bubble   = 1'b1;
          exmem_we = 1'b1;
          memwb_we = 1'b1;
          if (drain_q == '0) state_d = ST_DONE;
          else               drain_d = drain_q - DW'(1);
        end
      end
      ST_DONE: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  assign cycle_inc = (state_q == ST_RUN) || (state_q == ST_MEMWAIT) || (state_q == ST_DRAIN);

  perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i(clk_i), .clr_i(rst_i), .en_i(stall_inc), .cnt_o(stall_q)
  );
  perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i(clk_i), .clr_i(rst_i), .en_i(flush_inc), .cnt_o(flush_q)
  );
  perf_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
    .clk_i(clk_i), .clr_i(rst_i), .en_i(memwait_inc), .cnt_o(memwait_q)
  );
  perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk_i(clk_i), .clr_i(rst_i), .en_i(cycle_inc), .cnt_o(cycle_q)
  );

  // Everything reads as zero while reset is held, even before the first edge.
  assign bus.pc_write    = pc_we    && !rst_i;
  assign bus.ifid_write  = ifid_we  && !rst_i;
  assign bus.ifid_flush  = flush    && !rst_i;
  assign bus.idex_bubble = bubble   && !rst_i;
  assign bus.exmem_write = exmem_we && !rst_i;
  assign bus.memwb_write = memwb_we && !rst_i;

  assign running_o     = !rst_i && ((state_q == ST_RUN) || (state_q == ST_MEMWAIT));
  assign done_o        = !rst_i && (state_q == ST_DONE);
  assign stall_cnt_o   = rst_i ? '0 : stall_q;
  assign flush_cnt_o   = rst_i ? '0 : flush_q;
  assign memwait_cnt_o = rst_i ? '0 : memwait_q;
  assign cycle_cnt_o   = rst_i ? '0 : cycle_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed self-checking bench for pipe_ctrl
module tb_pipe_ctrl;

  localparam int CNT_W = 32;
  // {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write, memwb_write}
  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_ALL   = 6'b110011;
  localparam logic [5:0] C_STALL = 6'b000111;
  localparam logic [5:0] C_FLUSH = 6'b111011;
  localparam logic [5:0] C_DRAIN = 6'b000111;

  logic clk = 1'b0;
  logic rst;
  logic running, done;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, memwait_cnt, cycle_cnt;
  int compared = 0;
  int mismatched = 0;

  pipe_ctrl_if bus ();

  pipe_ctrl #(.CNT_W(CNT_W), .DRAIN_CYCLES(4)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus),
    .running_o(running), .done_o(done),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
    .memwait_cnt_o(memwait_cnt), .cycle_cnt_o(cycle_cnt)
  );

  always #5 clk = ~clk;

  wire [5:0] ctl = {bus.pc_write, bus.ifid_write, bus.ifid_flush,
                    bus.idex_bubble, bus.exmem_write, bus.memwb_write};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.halt = 0; bus.idex_memread = 0;
    bus.idex_rt = 0; bus.ifid_rs = 0; bus.ifid_rt = 0;
    bus.branch_taken = 0; bus.jump = 0; bus.dmem_req = 0; bus.dmem_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs();
    tick(); tick(); #3;
    compared++; if (ctl !== C_NONE) begin mismatched++; $display("FAIL rst_ctl: got %b want %b", ctl, C_NONE); end
    compared++; if ({running, done} !== 2'b00) begin mismatched++; $display("FAIL rst_status: got %b want 00", {running, done}); end
    compared++; if (cycle_cnt !== 0) begin mismatched++; $display("FAIL rst_cycle_cnt: got %0d want 0", cycle_cnt); end
    tick(); rst = 0; #3;
    compared++; if ({ctl, running, done} !== 8'b0) begin mismatched++; $display("FAIL idle_outputs: got %b want 0", {ctl, running, done}); end
  endtask

  task automatic test_start();
    tick(); bus.start = 1; #3;
    compared++; if (ctl !== C_NONE) begin mismatched++; $display("FAIL start_idle_ctl: got %b want %b", ctl, C_NONE); end
    tick(); bus.start = 0; #3;
    compared++; if (running !== 1'b1) begin mismatched++; $display("FAIL start_running: got %b want 1", running); end
    compared++; if (ctl !== C_ALL) begin mismatched++; $display("FAIL start_ctl: got %b want %b", ctl, C_ALL); end
    compared++; if (cycle_cnt !== 0) begin mismatched++; $display("FAIL start_cycle0: got %0d want 0", cycle_cnt); end
    tick(); #3;
    tick(); #3;
    tick(); #3;
    compared++; if (cycle_cnt !== 3) begin mismatched++; $display("FAIL start_cycle3: got %0d want 3", cycle_cnt); end
  endtask

  task automatic test_load_use();
    tick(); bus.idex_memread = 1; bus.idex_rt = 8; bus.ifid_rs = 8; bus.ifid_rt = 3; #3;
    compared++; if (ctl !== C_STALL) begin mismatched++; $display("FAIL lu_rs_ctl: got %b want %b", ctl, C_STALL); end
    tick(); bus.idex_memread = 0; #3;
    compared++; if (ctl !== C_ALL) begin mismatched++; $display("FAIL lu_clear_ctl: got %b want %b", ctl, C_ALL); end
    compared++; if (stall_cnt !== 1) begin mismatched++; $display("FAIL lu_stall1: got %0d want 1", stall_cnt); end
    tick(); bus.idex_memread = 1; bus.idex_rt = 0; bus.ifid_rs = 0; bus.ifid_rt = 0; #3;
    compared++; if (ctl !== C_ALL) begin mismatched++; $display("FAIL lu_r0_ctl: got %b want %b", ctl, C_ALL); end
    tick(); bus.idex_rt = 9; bus.ifid_rs = 2; bus.ifid_rt = 9; #3;
    compared++; if (ctl !== C_STALL) begin mismatched++; $display("FAIL lu_rt_ctl: got %b want %b", ctl, C_STALL); end
    compared++; if (stall_cnt !== 1) begin mismatched++; $display("FAIL lu_r0_nocount: got %0d want 1", stall_cnt); end
    tick(); clear_inputs(); #3;
    compared++; if (stall_cnt !== 2) begin mismatched++; $display("FAIL lu_stall2: got %0d want 2", stall_cnt); end
  endtask

  task automatic test_branch_hazard();
    tick(); bus.branch_taken = 1; bus.idex_memread = 1; bus.idex_rt = 8; bus.ifid_rs = 8; #3;
    compared++; if (ctl !== C_STALL) begin mismatched++; $display("FAIL br_hz_ctl: got %b want %b", ctl, C_STALL); end
    tick(); bus.idex_memread = 0; #3;
    compared++; if (ctl !== C_FLUSH) begin mismatched++; $display("FAIL br_flush_ctl: got %b want %b", ctl, C_FLUSH); end
    compared++; if (flush_cnt !== 0) begin mismatched++; $display("FAIL br_flush0: got %0d want 0", flush_cnt); end
    tick(); bus.branch_taken = 0; #3;
    compared++; if (ctl !== C_ALL) begin mismatched++; $display("FAIL br_after_ctl: got %b want %b", ctl, C_ALL); end
    compared++; if (flush_cnt !== 1) begin mismatched++; $display("FAIL br_flush1: got %0d want 1", flush_cnt); end
    compared++; if (stall_cnt !== 3) begin mismatched++; $display("FAIL br_stall3: got %0d want 3", stall_cnt); end
    tick(); bus.jump = 1; #3;
    compared++; if (ctl !== C_FLUSH) begin mismatched++; $display("FAIL jmp_ctl: got %b want %b", ctl, C_FLUSH); end
    tick(); bus.jump = 0; #3;
    compared++; if (flush_cnt !== 2) begin mismatched++; $display("FAIL jmp_flush2: got %0d want 2", flush_cnt); end
  endtask

  task automatic test_memwait();
    tick(); bus.dmem_req = 1; bus.dmem_ready = 0; #3;
    compared++; if (ctl !== C_NONE) begin mismatched++; $display("FAIL mw1_ctl: got %b want %b", ctl, C_NONE); end
    compared++; if (running !== 1'b1) begin mismatched++; $display("FAIL mw1_running: got %b want 1", running); end
    tick(); bus.halt = 1; #3;
    compared++; if (ctl !== C_NONE) begin mismatched++; $display("FAIL mw2_ctl: got %b want %b", ctl, C_NONE); end
    tick(); bus.halt = 0; #3;
    compared++; if (ctl !== C_NONE) begin mismatched++; $display("FAIL mw3_ctl: got %b want %b", ctl, C_NONE); end
    compared++; if (memwait_cnt !== 2) begin mismatched++; $display("FAIL mw3_cnt: got %0d want 2", memwait_cnt); end
    tick(); bus.dmem_ready = 1; #3;
    compared++; if (ctl !== C_ALL) begin mismatched++; $display("FAIL mw_ready_ctl: got %b want %b", ctl, C_ALL); end
    compared++; if (memwait_cnt !== 3) begin mismatched++; $display("FAIL mw_cnt3: got %0d want 3", memwait_cnt); end
    tick(); bus.dmem_req = 0; bus.dmem_ready = 0; #3;
    compared++; if ({ctl, running} !== {C_ALL, 1'b1}) begin mismatched++; $display("FAIL mw_resume: got %b want %b", {ctl, running}, {C_ALL, 1'b1}); end
    compared++; if (memwait_cnt !== 3) begin mismatched++; $display("FAIL mw_cnt_hold: got %0d want 3", memwait_cnt); end
  endtask

  task automatic test_drain();
    tick(); bus.halt = 1; #3;
    compared++; if (ctl !== C_ALL) begin mismatched++; $display("FAIL halt_cycle_ctl: got %b want %b", ctl, C_ALL); end
    tick(); bus.halt = 0; #3;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin tick(); #3; end
      compared++; if ({ctl, running, done} !== {C_DRAIN, 2'b00}) begin
        mismatched++; $display("FAIL drain%0d: got %b want %b", i, {ctl, running, done}, {C_DRAIN, 2'b00});
      end
    end
    tick(); #3;
    compared++; if ({ctl, done} !== {C_NONE, 1'b1}) begin mismatched++; $display("FAIL drain_done: got %b want %b", {ctl, done}, {C_NONE, 1'b1}); end
    tick(); bus.start = 1; bus.halt = 1; #3;
    tick(); bus.start = 0; bus.halt = 0; #3;
    compared++; if ({ctl, running, done} !== {C_NONE, 2'b01}) begin mismatched++; $display("FAIL done_sticky: got %b want %b", {ctl, running, done}, {C_NONE, 2'b01}); end
  endtask

  task automatic test_reset_memwait();
    tick(); clear_inputs(); rst = 1;
    tick(); rst = 0; bus.start = 1; #3;
    tick(); bus.start = 0; bus.idex_memread = 1; bus.idex_rt = 5; bus.ifid_rs = 5; #3;
    compared++; if (ctl !== C_STALL) begin mismatched++; $display("FAIL rm_stall_ctl: got %b want %b", ctl, C_STALL); end
    tick(); bus.idex_memread = 0; bus.dmem_req = 1; bus.dmem_ready = 0; #3;
    tick(); #3;
    compared++; if ({running, ctl} !== {1'b1, C_NONE}) begin mismatched++; $display("FAIL rm_memwait: got %b want %b", {running, ctl}, {1'b1, C_NONE}); end
    compared++; if ({stall_cnt, memwait_cnt} !== {32'd1, 32'd1}) begin mismatched++; $display("FAIL rm_cnts: got %0d/%0d want 1/1", stall_cnt, memwait_cnt); end
    rst = 1; #1;
    compared++; if ({running, ctl, stall_cnt} !== '0) begin mismatched++; $display("FAIL rm_during_rst: got %b/%0d want 0", {running, ctl}, stall_cnt); end
    tick(); rst = 0; bus.dmem_req = 0; #3;
    compared++; if ({running, done, ctl} !== 8'b0) begin mismatched++; $display("FAIL rm_idle: got %b want 0", {running, done, ctl}); end
    compared++; if ({stall_cnt, flush_cnt, memwait_cnt, cycle_cnt} !== '0) begin
      mismatched++; $display("FAIL rm_cnt_clear: got %0d %0d %0d %0d want 0", stall_cnt, flush_cnt, memwait_cnt, cycle_cnt);
    end
  endtask

  task automatic test_drain_memwait();
    logic [5:0] frz;
    frz = 6'b000110;
    tick(); bus.start = 1; #3;
    tick(); bus.start = 0; bus.halt = 1; #3;
    compared++; if (ctl !== C_ALL) begin mismatched++; $display("FAIL dm_halt_ctl: got %b want %b", ctl, C_ALL); end
    for (int i = 0; i < 6; i++) begin
      tick(); bus.halt = 0; bus.dmem_req = frz[i]; bus.dmem_ready = 0; #3;
      compared++; if ({ctl, done} !== {(frz[i] ? C_NONE : C_DRAIN), 1'b0}) begin
        mismatched++; $display("FAIL dm_cycle%0d: got %b want %b", i, {ctl, done}, {(frz[i] ? C_NONE : C_DRAIN), 1'b0});
      end
    end
    tick(); bus.dmem_req = 0; #3;
    compared++; if ({ctl, done} !== {C_NONE, 1'b1}) begin mismatched++; $display("FAIL dm_done: got %b want %b", {ctl, done}, {C_NONE, 1'b1}); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_load_use();
    test_branch_hazard();
    test_memwait();
    test_drain();
    test_reset_memwait();
    test_drain_memwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
